aes_spi_frontend: RTL and testbench
===================================

Name: aes_spi_frontend

Overview:
SPI mode-0 target that lets an external host drive the static-key AES core. It owns the core's load_i/dec_i/data_i handshake and observes busy_o/data_o. The host shifts in a 128-bit block with an encrypt or decrypt opcode, polls status, and shifts out the result. It sits between the board SPI pins and aes_core_static_128_scanchain. The scan pins are not handled here.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the synchronisers on spi_sck, spi_cs_n and spi_mosi (minimum 2).
BLOCK_BYTES, 16, payload length in bytes for write and read opcodes (fixed for AES-128).

Ports:
clk  input  1  system clock; the single clock domain.
rst_n  input  1  asynchronous active-low reset.
spi_sck  input  1  SPI clock, asynchronous to clk; f_sck <= f_clk/8.
spi_cs_n  input  1  SPI chip select, active low.
spi_mosi  input  1  SPI data in, MSB first.
spi_miso  output  1  SPI data out, MSB first.
aes_load_o  output  1  one-cycle load strobe to core load_i.
aes_dec_o  output  1  to core dec_i; 1 = decrypt.
aes_data_o  output  128  block to core data_i.
aes_busy_i  input  1  from core busy_o.
aes_data_i  input  128  from core data_o.
done_o  output  1  level, mirrors status.done.

Behaviour:
- Reset is asynchronous and active-low (rst_n); all state is clocked on clk.
- Reset values: spi_miso=0, aes_load_o=0, aes_dec_o=0, aes_data_o=0, done_o=0, result register=0, err=0, FSM=IDLE.
- Synchronisers:
  - sck, cs_n and mosi each pass through SYNC_STAGES flops.
  - sck_rise and sck_fall are single-cycle pulses taken from the last two synchronised sck samples.
  - cs_fall is a single-cycle pulse; cs_n high is treated as a level.
- SPI framing:
  - mosi is sampled on sck_rise; spi_miso is updated on sck_fall.
  - The bit counter resets on cs_fall. The first byte is the opcode.
- FSM states: IDLE, CMD, RX, TX, IGNORE.
  - IDLE -> CMD on cs_fall.
  - CMD: after 8 rising edges, decode the opcode:
    - 0x01 (ENC) or 0x02 (DEC) -> RX.
    - 0x03 (READ): load the tx shifter with the result register -> TX.
    - 0x04 (STATUS): load the tx shifter with {5'b0, err, done, aes_busy_i} followed by zero padding -> TX; err clears at this load.
    - Any other value -> IGNORE.
  - RX: shift mosi into a 128-bit rx buffer. After the 128th data bit, raise a one-cycle request, then -> IGNORE.
  - TX: on each sck_fall, drive the next bit. The first payload bit is driven on the 8th falling edge (the end of the opcode byte), so it is valid before payload rising edge 1. After 8*BLOCK_BYTES bits (READ) or 8 bits (STATUS) -> IGNORE.
  - IGNORE: spi_miso=0; remaining clocks are discarded.
  - Any state -> IDLE when cs_n is high. Abort mid-RX means no load; aes_data_o is unchanged.
- spi_miso is 0 in IDLE, CMD and IGNORE.
- Load handshake:
  - On the request cycle, if aes_busy_i=0: next clk cycle aes_load_o=1 for exactly one cycle, aes_data_o=rx buffer, aes_dec_o=(opcode==0x02), done cleared.
  - If aes_busy_i=1 on the request cycle: no load, err set to 1 (sticky until a STATUS read).
  - aes_data_o and aes_dec_o hold their values until the next accepted load.
- Completion:
  - A registered busy 1->0 transition captures aes_data_i into the result register and sets done.
  - A busy fall and a load request in the same cycle: capture happens and the load is accepted, because the request checks the live aes_busy_i=0. The load then clears done.
  - A READ during a busy phase returns the previous result register value.
- done_o equals done.
- Overlong transactions: extra bytes after the payload are ignored. A new cs_fall restarts framing.

Test Plan:
- Reset with spi_cs_n=1 -> all outputs 0; STATUS read returns 0x00.
- ENC opcode 0x01 + 00112233445566778899aabbccddeeff, core key 2b7e151628aed2a6abf7976676151301 -> one aes_load_o pulse, aes_dec_o=0, aes_data_o equals the block. After busy falls, STATUS=0x02 and READ returns bb543294c636da27e6701c7e66814a19.
- DEC opcode 0x02 + bb543294c636da27e6701c7e66814a19 -> aes_dec_o=1; READ returns 00112233445566778899aabbccddeeff.
- ENC sent while core busy (second frame immediately after the first load) -> no second load pulse; STATUS=0x05 while busy, or 0x06 after completion; the next STATUS has err cleared.
- cs_n raised after 9 payload bytes of an ENC frame -> no aes_load_o; aes_data_o unchanged; next frame decodes normally.
- Opcode 0x7F followed by 16 bytes -> spi_miso stays 0, no load, status unchanged.

Source files
------------

// File: rtl/aes_spi_frontend.sv
// SPI mode-0 target that lets a host drive the static-key AES core: opcode
// decode, 128-bit block transfer, core load handshake and result/status readback.
module aes_spi_frontend #(
  parameter int SYNC_STAGES = 2,
  parameter int BLOCK_BYTES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         spi_sck,
  input  logic         spi_cs_n,
  input  logic         spi_mosi,
  output logic         spi_miso,
  output logic         aes_load_o,
  output logic         aes_dec_o,
  output logic [127:0] aes_data_o,
  input  logic         aes_busy_i,
  input  logic [127:0] aes_data_i,
  output logic         done_o
);

  localparam int PAYLOAD_BITS = 8 * BLOCK_BYTES;
  localparam int CW = $clog2(PAYLOAD_BITS + 1);

  localparam logic [7:0] OP_ENC    = 8'h01;
  localparam logic [7:0] OP_DEC    = 8'h02;
  localparam logic [7:0] OP_READ   = 8'h03;
  localparam logic [7:0] OP_STATUS = 8'h04;

  typedef enum logic [2:0] {IDLE, CMD, RX, TX, IGNORE} state_t;
  state_t state, next_state;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic sck_prev, cs_prev;
  logic sck_s, cs_n_s, mosi_s;
  logic sck_rise, sck_fall, cs_fall;

  logic [CW-1:0] bit_cnt;
  logic [7:0]    op_sh, op_next;
  logic          is_dec, is_status;
  logic [127:0]  rx_buf, tx_sh, result;
  logic          miso_reg, req_q, busy_q, done, err;
  logic          cmd_shift, cmd_last, rx_shift, rx_req, tx_step, tx_done, miso_en;
  logic          rd_load, st_load, load_accept, busy_fall;

  // chip select idles high, so its synchroniser resets high to avoid a false cs_fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_prev  <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sck_prev  <= sck_s;
      cs_prev   <= cs_n_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_n_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;
  assign cs_fall  = cs_prev & ~cs_n_s;

  assign op_next  = {op_sh[6:0], mosi_s};
  assign cmd_last = cmd_shift && (bit_cnt == CW'(7));
  assign rx_req   = rx_shift && (bit_cnt == CW'(PAYLOAD_BITS - 1));
  assign tx_done  = bit_cnt == (is_status ? CW'(8) : CW'(PAYLOAD_BITS));
  assign rd_load  = cmd_last && (op_next == OP_READ);
  assign st_load  = cmd_last && (op_next == OP_STATUS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (cs_n_s) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: if (cs_fall) next_state = CMD;
        CMD: begin
          if (cmd_last) begin
            case (op_next)
              OP_ENC, OP_DEC:     next_state = RX;
              OP_READ, OP_STATUS: next_state = TX;
              default:            next_state = IGNORE;
            endcase
          end
        end
        RX:      if (rx_req) next_state = IGNORE;
        TX:      if (tx_step && tx_done) next_state = IGNORE;
        default: ;
      endcase
    end
  end

  always_comb begin
    cmd_shift = 1'b0;
    rx_shift  = 1'b0;
    tx_step   = 1'b0;
    miso_en   = 1'b0;
    case (state)
      CMD: cmd_shift = sck_rise & ~cs_n_s;
      RX:  rx_shift  = sck_rise & ~cs_n_s;
      TX: begin
        tx_step = sck_fall & ~cs_n_s;
        miso_en = 1'b1;
      end
      default: ;
    endcase
  end

  assign spi_miso = miso_en & miso_reg;

  // one counter serves opcode bits, rx payload bits and tx payload bits in turn
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      op_sh     <= '0;
      is_dec    <= 1'b0;
      is_status <= 1'b0;
      rx_buf    <= '0;
      tx_sh     <= '0;
      miso_reg  <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      req_q <= rx_req;
      if (cs_fall || cmd_last)
        bit_cnt <= '0;
      else if (cmd_shift || rx_shift || (tx_step && !tx_done))
        bit_cnt <= bit_cnt + CW'(1);
      if (cmd_shift) op_sh <= op_next;
      if (cmd_last) begin
        is_dec    <= (op_next == OP_DEC);
        is_status <= (op_next == OP_STATUS);
      end
      if (rx_shift) rx_buf <= {rx_buf[126:0], mosi_s};
      if (rd_load) begin
        tx_sh    <= result;
        miso_reg <= 1'b0;
      end else if (st_load) begin
        tx_sh    <= {5'b0, err, done, aes_busy_i, 120'b0};
        miso_reg <= 1'b0;
      end else if (tx_step && !tx_done) begin
        miso_reg <= tx_sh[127];
        tx_sh    <= {tx_sh[126:0], 1'b0};
      end
    end
  end

  // the request checks live busy, so a completion and a new load can share a cycle
  assign busy_fall   = busy_q & ~aes_busy_i;
  assign load_accept = req_q & ~aes_busy_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= 1'b0;
      aes_load_o <= 1'b0;
      aes_dec_o  <= 1'b0;
      aes_data_o <= '0;
      result     <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      busy_q     <= aes_busy_i;
      aes_load_o <= load_accept;
      if (load_accept) begin
        aes_data_o <= rx_buf;
        aes_dec_o  <= is_dec;
      end
      if (busy_fall) result <= aes_data_i;
      if (load_accept)    done <= 1'b0;
      else if (busy_fall) done <= 1'b1;
      if (req_q && aes_busy_i) err <= 1'b1;
      else if (st_load)        err <= 1'b0;
    end
  end

  assign done_o = done;

endmodule

// File: tb/tb_aes_spi_frontend.sv
// Directed bench for aes_spi_frontend: an SPI host task, a behavioural core
// stand-in and a load scoreboard compared whenever the DUT strobes aes_load_o.
module tb_aes_spi_frontend;

  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT   = 128'hbb543294c636da27e6701c7e66814a19;
  localparam logic [127:0] ALT  = 128'hdeadbeef0123456789abcdeffedcba98;
  localparam int           HALF = 6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         spi_sck = 1'b0;
  logic         spi_cs_n = 1'b1;
  logic         spi_mosi = 1'b0;
  logic         spi_miso;
  logic         aes_load_o;
  logic         aes_dec_o;
  logic [127:0] aes_data_o;
  logic         aes_busy_i;
  logic [127:0] aes_data_i;
  logic         done_o;

  int tests_run = 0;
  int tests_failed = 0;
  int busy_len = 40;
  int load_count = 0;
  int lc;

  always #5 clk = ~clk;

  aes_spi_frontend #(.SYNC_STAGES(2), .BLOCK_BYTES(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_sck    (spi_sck),
    .spi_cs_n   (spi_cs_n),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .aes_load_o (aes_load_o),
    .aes_dec_o  (aes_dec_o),
    .aes_data_o (aes_data_o),
    .aes_busy_i (aes_busy_i),
    .aes_data_i (aes_data_i),
    .done_o     (done_o)
  );

  function automatic logic [127:0] core_result(input logic [127:0] d, input logic dec);
    if (!dec && d == PT) return CT;
    if (dec && d == CT) return PT;
    return ~d;
  endfunction

  // core stand-in: busy for busy_len cycles, result appears as busy drops
  logic [127:0] core_in;
  logic         core_dec;
  int           core_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aes_busy_i <= 1'b0;
      aes_data_i <= '0;
      core_in    <= '0;
      core_dec   <= 1'b0;
      core_cnt   <= 0;
    end else if (aes_load_o && !aes_busy_i) begin
      aes_busy_i <= 1'b1;
      core_in    <= aes_data_o;
      core_dec   <= aes_dec_o;
      core_cnt   <= busy_len;
    end else if (aes_busy_i) begin
      if (core_cnt <= 1) begin
        aes_busy_i <= 1'b0;
        aes_data_i <= core_result(core_in, core_dec);
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [127:0] data;
    logic         dec;
  } load_t;
  load_t exp_q[$];
  logic  load_prev = 1'b0;

  always @(negedge clk) begin
    load_prev <= aes_load_o;
    if (rst_n && aes_load_o) begin
      load_t e;
      load_count <= load_count + 1;
      check_output("load_width", 128'(load_prev), 128'd0);
      check_output("load_expected", 128'(exp_q.size() > 0), 128'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("load_data", aes_data_o, e.data);
        check_output("load_dec", 128'(aes_dec_o), 128'(e.dec));
      end
    end
  end

  logic [7:0] tx_bytes [0:16];
  logic [7:0] rx_bytes [0:16];
  logic       miso_seen;

  task automatic apply_stimulus(input logic [7:0] op, input logic [127:0] data, input int nbytes);
    tx_bytes[0] = op;
    for (int i = 1; i <= 16; i++) tx_bytes[i] = data[128-8*i +: 8];
    miso_seen = 1'b0;
    @(negedge clk);
    spi_cs_n = 1'b0;
    for (int b = 0; b < nbytes; b++) begin
      for (int i = 7; i >= 0; i--) begin
        spi_mosi = tx_bytes[b][i];
        repeat (HALF) @(negedge clk);
        rx_bytes[b][i] = spi_miso;
        miso_seen = miso_seen | spi_miso;
        spi_sck = 1'b1;
        repeat (HALF) @(negedge clk);
        spi_sck = 1'b0;
      end
    end
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  function automatic logic [127:0] rx_block();
    logic [127:0] r = '0;
    for (int i = 1; i <= 16; i++) r = {r[119:0], rx_bytes[i]};
    return r;
  endfunction

  task automatic read_status(input string tag, input logic [7:0] exp);
    apply_stimulus(8'h04, '0, 2);
    check_output(tag, 128'(rx_bytes[1]), 128'(exp));
  endtask

  task automatic read_result(input string tag, input logic [127:0] exp);
    apply_stimulus(8'h03, '0, 17);
    check_output({tag, "_opbyte"}, 128'(rx_bytes[0]), 128'd0);
    check_output(tag, rx_block(), exp);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_output("rst_miso", 128'(spi_miso), 128'd0);
    check_output("rst_load", 128'(aes_load_o), 128'd0);
    check_output("rst_dec", 128'(aes_dec_o), 128'd0);
    check_output("rst_data", aes_data_o, 128'd0);
    check_output("rst_done", 128'(done_o), 128'd0);
    read_status("rst_status", 8'h00);

    // encrypt the reference block and read it back
    lc = load_count;
    exp_q.push_back({PT, 1'b0});
    apply_stimulus(8'h01, PT, 17);
    check_output("enc_loads", 128'(load_count - lc), 128'd1);
    check_output("enc_dec", 128'(aes_dec_o), 128'd0);
    check_output("enc_data", aes_data_o, PT);
    repeat (busy_len + 20) @(negedge clk);
    check_output("enc_done", 128'(done_o), 128'd1);
    read_status("enc_status", 8'h02);
    read_result("enc_read", CT);

    // decrypt it back
    lc = load_count;
    exp_q.push_back({CT, 1'b1});
    apply_stimulus(8'h02, CT, 17);
    check_output("dec_loads", 128'(load_count - lc), 128'd1);
    check_output("dec_dec", 128'(aes_dec_o), 128'd1);
    repeat (busy_len + 20) @(negedge clk);
    read_result("dec_read", PT);

    // second write lands while the core is still busy
    busy_len = 5000;
    lc = load_count;
    exp_q.push_back({PT, 1'b0});
    apply_stimulus(8'h01, PT, 17);
    check_output("busy_done_cleared", 128'(done_o), 128'd0);
    apply_stimulus(8'h01, ALT, 17);
    check_output("busy_loads", 128'(load_count - lc), 128'd1);
    check_output("busy_data_kept", aes_data_o, PT);
    read_status("busy_status_err", 8'h05);
    read_status("busy_status_clr", 8'h01);
    read_result("busy_read_prev", PT);
    repeat (busy_len) @(negedge clk);
    read_status("busy_status_done", 8'h02);
    read_result("busy_read_new", CT);

    // abort mid-payload, then a normal frame
    busy_len = 40;
    lc = load_count;
    apply_stimulus(8'h01, ALT, 10);
    check_output("abort_loads", 128'(load_count - lc), 128'd0);
    check_output("abort_data", aes_data_o, PT);
    read_status("abort_status", 8'h02);
    exp_q.push_back({CT, 1'b1});
    apply_stimulus(8'h02, CT, 17);
    check_output("after_abort_loads", 128'(load_count - lc), 128'd1);
    repeat (busy_len + 20) @(negedge clk);
    read_result("after_abort_read", PT);

    // unknown opcode is ignored
    lc = load_count;
    apply_stimulus(8'h7F, ALT, 17);
    check_output("badop_miso", 128'(miso_seen), 128'd0);
    check_output("badop_loads", 128'(load_count - lc), 128'd0);
    read_status("badop_status", 8'h02);

    check_output("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
